// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG test access port.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // Fixed pattern loaded into the IR shift stage in CAP_IR (LSB first: 1, 0, ...)
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    localparam int BYPASS_LEN = 1;
    localparam int IDCODE_LEN = 32;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller with decoded per-state strobes.
//
// state  | meaning
// -------+-------------------------------------------
// TLR    | test-logic-reset, IR forced to IDCODE
// RTI    | run-test/idle
// SEL_DR | select DR scan
// CAP_DR | capture selected DR
// SH_DR  | shift selected DR
// EX1_DR | exit1 DR
// PAU_DR | pause DR, contents held
// EX2_DR | exit2 DR
// UPD_DR | update selected DR
// SEL_IR | select IR scan
// CAP_IR | capture IR pattern
// SH_IR  | shift IR
// EX1_IR | exit1 IR
// PAU_IR | pause IR, contents held
// EX2_IR | exit2 IR
// UPD_IR | update IR
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trst_n,
    input  logic tms,
    output logic tlr,
    output logic cap_ir,
    output logic sh_ir,
    output logic upd_ir,
    output logic cap_dr,
    output logic sh_dr,
    output logic upd_dr
);

    tap_state_t state;
    tap_state_t state_next;

    // State register, reset lands in TLR
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state transitions on TMS and decoded strobes
    always_comb begin
        state_next = state;
        case (state)
            TLR:     state_next = tms ? TLR    : RTI;
            RTI:     state_next = tms ? SEL_DR : RTI;
            SEL_DR:  state_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_next = tms ? EX1_DR : SH_DR;
            SH_DR:   state_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_next = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_next = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_next = tms ? SEL_DR : RTI;
            SEL_IR:  state_next = tms ? TLR    : CAP_IR;
            CAP_IR:  state_next = tms ? EX1_IR : SH_IR;
            SH_IR:   state_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_next = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_next = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_next = tms ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase

        // tlr flags the edge that enters (or stays in) TLR so the IR resets with it
        tlr    = (state_next == TLR);
        cap_ir = (state == CAP_IR);
        sh_ir  = (state == SH_IR);
        upd_ir = (state == UPD_IR);
        cap_dr = (state == CAP_DR);
        sh_dr  = (state == SH_DR);
        upd_dr = (state == UPD_DR);
    end

endmodule

// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP: controller, instruction register, BYPASS/IDCODE/user TDR bank
// and negedge-timed TDO output.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int              IR_W         = 5,
    parameter int              DR_W         = 8,
    parameter int              NUM_TDR      = 4,
    parameter logic [31:0]     IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_W-1:0] OP_IDCODE    = IR_W'(1),
    parameter logic [IR_W-1:0] OP_USER_BASE = IR_W'(2)
) (
    input  logic                    TCK,
    input  logic                    TRST_N,
    input  logic                    TMS,
    input  logic                    TDI,
    output logic                    TDO,
    output logic                    TDO_EN,
    output logic [IR_W-1:0]         IR_OUT,
    input  logic [NUM_TDR*DR_W-1:0] TDR_CAP,
    output logic [NUM_TDR*DR_W-1:0] TDR_OUT,
    output logic [NUM_TDR-1:0]      TDR_UPD
);

    logic tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;

    logic [IR_W-1:0]       ir;
    logic [IR_W-1:0]       ir_sh;
    logic                  byp_sh;
    logic [IDCODE_LEN-1:0] id_sh;
    logic [DR_W-1:0]       tdr_sh;

    logic [IR_W-1:0]       tdr_idx;
    logic                  sel_id;
    logic                  sel_tdr;
    logic [NUM_TDR-1:0]    tdr_oh;
    logic [DR_W-1:0]       cap_val;
    logic                  dr_lsb;

    logic [NUM_TDR*DR_W-1:0] tdr_out;
    logic [NUM_TDR-1:0]      tdr_upd;
    logic                    tdo_q;
    logic                    tdo_en_q;

    jtag_tap_fsm u_fsm (
        .tck    (TCK),
        .trst_n (TRST_N),
        .tms    (TMS),
        .tlr    (tlr),
        .cap_ir (cap_ir),
        .sh_ir  (sh_ir),
        .upd_ir (upd_ir),
        .cap_dr (cap_dr),
        .sh_dr  (sh_dr),
        .upd_dr (upd_dr)
    );

    // DR select from the updated IR only; anything unrecognised is BYPASS
    always_comb begin
        tdr_idx = ir - OP_USER_BASE;
        sel_id  = (ir == OP_IDCODE);
        sel_tdr = !sel_id && (ir != '1) && (ir >= OP_USER_BASE)
                  && ({1'b0, tdr_idx} < (IR_W+1)'(NUM_TDR));
        tdr_oh  = '0;
        cap_val = '0;
        for (int k = 0; k < NUM_TDR; k++) begin
            if (sel_tdr && (tdr_idx == IR_W'(k))) begin
                tdr_oh[k] = 1'b1;
                cap_val   = TDR_CAP[k*DR_W +: DR_W];
            end
        end
        dr_lsb = sel_id ? id_sh[0] : (sel_tdr ? tdr_sh[0] : byp_sh);
    end

    // Instruction shift stage and updated instruction
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sh <= '0;
            ir    <= OP_IDCODE;
        end else begin
            if (cap_ir) begin
                ir_sh <= IR_W'(IR_CAPTURE);
            end else if (sh_ir) begin
                ir_sh <= IR_W'({TDI, ir_sh} >> 1);
            end
            if (tlr) begin
                ir <= OP_IDCODE;
            end else if (upd_ir) begin
                ir <= ir_sh;
            end
        end
    end

    // Data-register shift stages; one TDR stage is shared since only one is selected
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            byp_sh <= 1'b0;
            id_sh  <= '0;
            tdr_sh <= '0;
        end else if (cap_dr) begin
            byp_sh <= 1'b0;
            if (sel_id) begin
                id_sh <= IDCODE_VAL;
            end
            if (sel_tdr) begin
                tdr_sh <= cap_val;
            end
        end else if (sh_dr) begin
            if (sel_id) begin
                id_sh <= IDCODE_LEN'({TDI, id_sh} >> 1);
            end else if (sel_tdr) begin
                tdr_sh <= DR_W'({TDI, tdr_sh} >> 1);
            end else begin
                byp_sh <= TDI;
            end
        end
    end

    // TDR parallel outputs and single-cycle update strobes
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdr_out <= '0;
            tdr_upd <= '0;
        end else begin
            tdr_upd <= '0;
            if (upd_dr) begin
                for (int k = 0; k < NUM_TDR; k++) begin
                    if (tdr_oh[k]) begin
                        tdr_out[k*DR_W +: DR_W] <= tdr_sh;
                    end
                end
                tdr_upd <= tdr_oh;
            end
        end
    end

    // TDO launched on falling TCK so it is stable for the next rising-edge sample
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= sh_ir | sh_dr;
            tdo_q    <= sh_ir ? ir_sh[0] : (sh_dr ? dr_lsb : 1'b0);
        end
    end

    assign TDO     = tdo_q;
    assign TDO_EN  = tdo_en_q;
    assign IR_OUT  = ir;
    assign TDR_OUT = tdr_out;
    assign TDR_UPD = tdr_upd;

endmodule
